// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of one multi-cycle memory between fetch and data ports
// One outstanding transaction; a watchdog forces completion if memory never answers.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_valid,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     d_valid,
  output logic                     stall_f,
  output logic                     stall_m,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_last_grant;
  logic                     r_owner;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_if_rdata;
  logic [DATA_WIDTH-1:0]    r_d_rdata;
  logic [15:0]              r_cnt;
  logic                     r_timeout_err;

  logic w_any_req;
  logic w_grant_d;
  logic w_busy;
  logic w_complete;
  logic w_expire;

  // On a tie the requester that did not win last time gets the grant
  assign w_any_req  = if_req | d_req;
  assign w_grant_d  = d_req & (~if_req | (r_last_grant == OWN_IF));
  assign w_busy     = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign w_complete = (r_state == S_WAIT) & mem_rvalid;
  assign w_expire   = w_busy & (r_cnt == LP_CNT_LAST) & ~w_complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_expire)       w_next = S_DONE;
        else if (mem_ready) w_next = S_WAIT;
      end
      S_WAIT:  if (w_complete | w_expire) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    if_valid = 1'b0;
    d_valid  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        mem_req = 1'b1;
        mem_we  = r_we;
      end
      S_DONE: begin
        if_valid = (r_owner == OWN_IF);
        d_valid  = (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant  <= OWN_IF;
      r_owner       <= OWN_IF;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner      <= w_grant_d;
        r_last_grant <= w_grant_d;
        r_we         <= w_grant_d & d_we;
        r_addr       <= w_grant_d ? d_addr : if_addr;
        r_wdata      <= w_grant_d ? d_wdata : '0;
        r_cnt        <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_complete) begin
        if (r_owner == OWN_D) r_d_rdata  <= mem_rdata;
        else                  r_if_rdata <= mem_rdata;
      end else if (w_expire) begin
        if (r_owner == OWN_D) r_d_rdata  <= '0;
        else                  r_if_rdata <= '0;
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign timeout_err = r_timeout_err;
  assign stall_f     = if_req & ~if_valid;
  assign stall_m     = d_req & ~d_valid;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares one single-port, multi-cycle backing memory between the fetch stage (read-only) and the memory stage (loads and stores).
- Sits between the pipeline's fetch/memory stages and the unified main memory. Produces per-requester stall signals so the pipeline freezes while its access is pending.
- Round-robin arbitration with one outstanding transaction.
- A watchdog guarantees a response even if memory never answers.

Parameters:
- ADDRESS_WIDTH, 32, width of all address ports
- DATA_WIDTH, 32, width of all data ports
- TIMEOUT, 255, max cycles spent in ISSUE+WAIT before forced completion (1..2^16-1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held until if_valid
- if_addr  in  ADDRESS_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetch read data; valid while if_valid=1
- if_valid  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDRESS_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid while d_valid=1
- d_valid  out  1  one-cycle completion pulse for data
- stall_f  out  1  if_req & ~if_valid (combinational)
- stall_m  out  1  d_req & ~d_valid (combinational)
- mem_req  out  1  memory request strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory completion (reads and writes); one pulse per accepted request
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_rvalid
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_grant=IF; watchdog counter=0; latched request registers=0.
  - All outputs 0: if_valid, d_valid, mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, timeout_err.
  - Reset mid-transaction abandons the transaction silently. No valid pulse is issued; any later mem_rvalid is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Only d_req=1: grant D.
  - Only if_req=1: grant IF.
  - Both requests: grant the requester that is not last_grant. After reset, D therefore wins the first tie.
  - On grant: latch owner, addr, we (forced 0 for IF), wdata; update last_grant; clear counter; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_req=1; mem_we/addr/wdata come from the latched registers. mem_* are stable for the whole ISSUE state.
  - mem_ready=1: go to WAIT.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: capture mem_rdata into the owner's rdata register; go to DONE.
  - mem_rvalid is never accepted in the ISSUE cycle itself.
- DONE:
  - Owner's valid=1 for exactly one cycle, then IDLE.
  - The rdata register holds its value until that owner's next completion.
  - For stores, the rdata register is loaded with mem_rdata and its content is don't-care.
- Minimum latency: request sampled in IDLE at cycle 0 gives ISSUE at 1, WAIT at 2 (rvalid), valid at cycle 3.
- The other requester waits for at least the full transaction plus one IDLE cycle.
- Watchdog:
  - Counter increments every cycle in ISSUE or WAIT.
  - When counter==TIMEOUT-1 and no completion event occurs that cycle: load 0 into the owner's rdata, set timeout_err, go to DONE (valid pulse still issued).
  - Completion in the same cycle as expiry counts as normal completion; timeout_err is not set.
- Requester contract: req, addr, we, wdata are held stable until the edge at which valid=1. The requester may drop or change its request at that edge.
- Request changes while not owner are ignored until the next IDLE grant. Changes by the owner after grant have no effect (request is latched).
- Deasserting req while owning a transaction does not abort it; the completion pulse is still issued.
- if_valid and d_valid are never high in the same cycle. mem_req is never high outside ISSUE.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10; memory ready immediately, rvalid next cycle with 0xDEADBEEF -> mem_req=1 at cycle 1 only; if_valid at cycle 3 with if_rdata=0xDEADBEEF; stall_f=1 in cycles 0-2.
- Simultaneous requests after reset: if_req=d_req=1 (load 0x20), both held -> D served first (d_valid at cycle 3), then IF (mem_addr=if_addr next ISSUE); the next tie goes to D again after IF.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678, mem_ready delayed 4 cycles -> mem_req held with mem_we=1, addr/data stable for 5 cycles; d_valid one pulse after rvalid; mem_we=0 in the next fetch.
- Timeout: TIMEOUT=8, if_req=1, mem_ready=1, no rvalid -> if_valid at cycle 9 (ISSUE entered at 1, expiry at counter 7) with if_rdata=0; timeout_err=1 and stays 1 through later normal transactions.
- Reset mid-WAIT: assert rst=0 during WAIT, then release; late mem_rvalid arrives -> no valid pulse; all outputs 0; next tie grants D.
- Starvation check: d_req held continuously issuing back-to-back loads while if_req=1 -> grants alternate D, IF, D, IF.
